// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD to binary converter.
// The digit-adjust constants implement the reverse double-dabble correction.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int         BCD_DIGIT_W   = 4;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] DD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] DD_ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double dabble:
// a digit that reached 8 or more after the right shift has 3 taken off.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= DD_ADJ_THRESH) ? (digit - DD_ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to binary converter (reverse double dabble, one shift
// per clock) with invalid-digit detection and saturating overflow.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4*DIGITS-1:0]       Ip_BCD,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [BIN_W-1:0]          op_Bin,
  output logic                      overflow,
  output logic                      err_digit,
  output logic [1:0]                state_dbg
);

  // Handshake: a request is accepted on a rising edge where start=1 and
  // ready=1; start while ready=0 is dropped, never queued. Ip_BCD only needs
  // to be valid on the accept edge. done is a one-cycle pulse and the result
  // outputs hold their value until the next done.

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BCD_W);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BCD_W - 1);

  conv_state_t        state;
  conv_state_t        state_next;
  logic [BCD_W-1:0]   bcd_r;
  logic [BCD_W-1:0]   bin_r;
  logic [CNT_W-1:0]   cnt;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bin_sh;
  logic [BCD_W-1:0]   bcd_adj;
  logic               bad_digit;
  logic               accept_ok;
  logic               accept_err;
  logic               last_iter;
  logic               hi_set;
  logic [BIN_W-1:0]   sat_bin;

  // Combined {bcd_r, bin_r} shifted right by one bit.
  assign bcd_sh = {1'b0, bcd_r[BCD_W-1:1]};
  assign bin_sh = {bcd_r[0], bin_r[BCD_W-1:1]};

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (bcd_sh[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Bits above BIN_W in the final shifted value mean the decimal input
  // does not fit; the result then saturates to all-ones.
  if (BIN_W < BCD_W) begin : g_sat
    assign hi_set  = |bin_sh[BCD_W-1:BIN_W];
    assign sat_bin = hi_set ? {BIN_W{1'b1}} : bin_sh[BIN_W-1:0];
  end else begin : g_nosat
    assign hi_set  = 1'b0;
    assign sat_bin = BIN_W'(bin_sh);
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (Ip_BCD[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX_DIGIT) bad_digit = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    accept_ok  = 1'b0;
    accept_err = 1'b0;
    last_iter  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (bad_digit) begin
            accept_err = 1'b1;
            state_next = DONE;
          end else begin
            accept_ok  = 1'b1;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (cnt == LAST_ITER) begin
          last_iter  = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bcd_r     <= '0;
      bin_r     <= '0;
      cnt       <= '0;
      op_Bin    <= '0;
      overflow  <= 1'b0;
      err_digit <= 1'b0;
    end else begin
      state <= state_next;
      if (accept_ok) begin
        bcd_r <= Ip_BCD;
        bin_r <= '0;
        cnt   <= '0;
      end else if (state == SHIFT) begin
        bcd_r <= bcd_adj;
        bin_r <= bin_sh;
        cnt   <= cnt + 1'b1;
      end
      if (accept_err) begin
        op_Bin    <= '0;
        overflow  <= 1'b0;
        err_digit <= 1'b1;
      end else if (last_iter) begin
        op_Bin    <= sat_bin;
        overflow  <= hi_set;
        err_digit <= 1'b0;
      end
    end
  end

  assign ready     = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Bench for bcd_to_binary_seq: directed corner cases plus random BCD words,
// checked against a decimal-arithmetic reference model.
module tb_bcd_to_binary_seq;
  import bcd_pkg::*;

  localparam int DIGITS  = 5;
  localparam int BIN_W   = 14;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int MAX_BIN = (1 << BIN_W) - 1;
  localparam int LAT_OK  = 4 * DIGITS + 1;
  localparam int LAT_ERR = 1;
  localparam int TIMEOUT = 100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [BCD_W-1:0] ip_bcd = '0;
  logic             ready, busy, done, overflow, err_digit;
  logic [BIN_W-1:0] op_bin;
  logic [1:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {err, ovf, op} per accepted request.
  logic [BIN_W+1:0] exp_q[$];
  logic [BIN_W-1:0] prev_op  = '0;
  logic             prev_ovf = 1'b0;
  logic             prev_err = 1'b0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .Ip_BCD    (ip_bcd),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .op_Bin    (op_bin),
    .overflow  (overflow),
    .err_digit (err_digit),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: decimal interpretation of the packed digits.
  function automatic logic [BIN_W+1:0] model(input logic [BCD_W-1:0] bcd);
    int   val;
    logic err;
    logic [3:0] d;
    val = 0;
    err = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = bcd[i*4 +: 4];
      if (d > 4'd9) err = 1'b1;
      val = val * 10 + int'(d);
    end
    if (err) return {1'b1, 1'b0, BIN_W'(0)};
    if (val > MAX_BIN) return {1'b0, 1'b1, BIN_W'(MAX_BIN)};
    return {1'b0, 1'b0, BIN_W'(val)};
  endfunction

  function automatic logic [BCD_W-1:0] rand_bcd(input bit allow_bad);
    logic [BCD_W-1:0] v;
    for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 7) == 0)
      v[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  // Called at a sample point with ready=1. Returns at the sample point of the
  // done cycle. With hold=1, start stays high and Ip_BCD keeps changing.
  task automatic run_conv(input string tag, input logic [BCD_W-1:0] bcd, input bit hold);
    logic [BIN_W+1:0] exp;
    int cycles;
    int exp_lat;
    exp = model(bcd);
    exp_lat = exp[BIN_W+1] ? LAT_ERR : LAT_OK;
    start  = 1'b1;
    ip_bcd = bcd;
    @(posedge clk); #1;
    exp_q.push_back(exp);
    if (!hold) start = 1'b0;
    ip_bcd = rand_bcd(1'b1);
    cycles = 1;
    while (!done && cycles < TIMEOUT) begin
      if (cycles == 2) check({tag, "_busy"}, busy, !exp[BIN_W+1]);
      if (cycles == 10 && !exp[BIN_W+1]) begin
        check({tag, "_hold_op"}, op_bin, prev_op);
        check({tag, "_hold_flags"}, {overflow, err_digit}, {prev_ovf, prev_err});
      end
      @(posedge clk); #1;
      if (hold) ip_bcd = rand_bcd(1'b1);
      cycles++;
    end
    start = 1'b0;
    if (!done) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_latency"}, cycles, exp_lat);
    check({tag, "_ready_in_done"}, ready, 0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      return;
    end
    exp = exp_q.pop_front();
    check({tag, "_op"}, op_bin, exp[BIN_W-1:0]);
    check({tag, "_ovf"}, overflow, exp[BIN_W]);
    check({tag, "_err"}, err_digit, exp[BIN_W+1]);
    prev_op  = exp[BIN_W-1:0];
    prev_ovf = exp[BIN_W];
    prev_err = exp[BIN_W+1];
  endtask

  // Step out of the DONE cycle; the block must be idle with done dropped.
  task automatic to_idle(input string tag);
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, ready, 1);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_done"}, done, 0);
  endtask

  initial begin
    int cycles;
    int done_seen;

    // Clock/reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op", op_bin, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err_digit, 0);
    check("rst_state", state_dbg, 2'(IDLE));

    // Directed corners
    run_conv("d9999", 20'h09999, 1'b0);  to_idle("d9999");
    run_conv("d16383", 20'h16383, 1'b0); to_idle("d16383");
    run_conv("d16384", 20'h16384, 1'b0); to_idle("d16384");
    run_conv("d99999", 20'h99999, 1'b0); to_idle("d99999");
    run_conv("dbad", 20'h0A123, 1'b0);   to_idle("dbad");
    run_conv("dzero", 20'h00000, 1'b0);  to_idle("dzero");

    // Start raised during DONE is dropped, then accepted once re-raised in IDLE
    run_conv("b2b_1", 20'h00001, 1'b0);
    start  = 1'b1;
    ip_bcd = 20'h12345;
    to_idle("b2b_drop");
    run_conv("b2b_2", 20'h12345, 1'b0);
    to_idle("b2b_2");

    // Reset in the middle of a conversion
    start  = 1'b1;
    ip_bcd = 20'h12345;
    @(posedge clk); #1;
    start  = 1'b0;
    cycles = 1;
    while (cycles < 10) begin
      @(posedge clk); #1;
      cycles++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_outs", {op_bin, overflow, err_digit}, 0);
    prev_op  = '0;
    prev_ovf = 1'b0;
    prev_err = 1'b0;
    done_seen = 0;
    repeat (4 * DIGITS + 5) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    run_conv("post_rst", 20'h00042, 1'b0); to_idle("post_rst");

    // Start held through SHIFT with Ip_BCD wandering
    run_conv("held", 20'h54321, 1'b1); to_idle("held");

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      run_conv("rnd", rand_bcd(1'b1), ($urandom_range(0, 3) == 0));
      to_idle("rnd");
    end

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
